// File: rtl/truth_table_sweeper.sv
// Purpose : sweeps every input vector of an NIN-input combinational DUT, captures its truth table and compares it to EXPECT.
// Latency : done rises 2^NIN*STEP_CYCLES edges after the accepted start; vector k sampled at E0+(k+1)*STEP_CYCLES.
// Backpres: none; start is ignored while sweeping, abort cancels a sweep, rst overrides everything.
//
// Ports:
//   clk, rst      single rising-edge clock, synchronous active-high reset
//   start, abort  sweep control (start accepted in IDLE/DONE, abort acts in SWEEP only)
//   dut_in        output of the circuit under test
//   vec_out       registered stimulus vector driven to the circuit under test
//   busy, done    sweep running / sweep completed (sticky until next start or reset)
//   table_out     captured table, bit i = response to vector i
//   ones_count    population count of table_out
//   match         table_out == EXPECT, meaningful while done=1
module truth_table_sweeper #(
    parameter int NIN         = 3,
    parameter int STEP_CYCLES = 1,
    parameter logic [(1<<NIN)-1:0] EXPECT = 8'b1001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dut_in,
    output logic [NIN-1:0]        vec_out,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<NIN)-1:0]   table_out,
    output logic [NIN:0]          ones_count,
    output logic                  match
);

    localparam int NVEC = 1 << NIN;
    // Hold counter only needs to reach STEP_CYCLES-1; keep at least one bit.
    localparam int HW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(STEP_CYCLES - 1);
    localparam logic [NIN-1:0] VEC_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold;
    logic [NVEC-1:0] tbl_nxt;

    // Table as it will look after the current sample; lets match include
    // the final bit written on the completing edge.
    always_comb begin
        tbl_nxt          = table_out;
        tbl_nxt[vec_out] = dut_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hold       <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
            match      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // start wins over abort here; abort alone does nothing
                    if (start) begin
                        state      <= S_SWEEP;
                        hold       <= '0;
                        vec_out    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        table_out  <= '0;
                        ones_count <= '0;
                        match      <= 1'b0;
                    end
                end

                S_SWEEP: begin
                    if (abort) begin
                        // partial table and count are left visible for debug
                        state   <= S_IDLE;
                        hold    <= '0;
                        vec_out <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        match   <= 1'b0;
                    end else if (hold != HOLD_LAST) begin
                        hold <= hold + HW'(1);
                    end else begin
                        hold       <= '0;
                        table_out  <= tbl_nxt;
                        ones_count <= ones_count + {{NIN{1'b0}}, dut_in};
                        if (vec_out != VEC_LAST) begin
                            vec_out <= vec_out + NIN'(1);
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (tbl_nxt == EXPECT);
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, abort1, dut_in1;
    logic [2:0] vec1;
    logic       busy1, done1, match1;
    logic [7:0] tbl1;
    logic [3:0] ones1;

    logic       start3, abort3, dut_in3;
    logic [2:0] vec3;
    logic       busy3, done3, match3;
    logic [7:0] tbl3;
    logic [3:0] ones3;

    logic       stuck;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [7:0] tbl;
        logic [3:0] ones;
        logic       m;
    } exp_t;

    exp_t q1[$];

    always #5 clk = ~clk;

    // Reference circuit X = A & ~(B ^ C), vector = {A,B,C}
    function automatic logic ref_fn(input logic [2:0] v);
        return v[2] & ~(v[1] ^ v[0]);
    endfunction

    assign dut_in1 = stuck ? 1'b0 : ref_fn(vec1);
    assign dut_in3 = ref_fn(vec3);

    truth_table_sweeper u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_in(dut_in1),
        .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tbl1),
        .ones_count(ones1), .match(match1)
    );

    truth_table_sweeper #(.NIN(3), .STEP_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .dut_in(dut_in3),
        .vec_out(vec3), .busy(busy3), .done(done3), .table_out(tbl3),
        .ones_count(ones3), .match(match3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input bit stk);
        exp_t e;
        logic b;
        e.tbl  = '0;
        e.ones = '0;
        for (int v = 0; v < 8; v++) begin
            b = stk ? 1'b0 : ref_fn(3'(v));
            e.tbl[v] = b;
            e.ones   = e.ones + 4'(b);
        end
        e.m = (e.tbl == 8'b1001_0000);
        return e;
    endfunction

    // Pulse start for one edge (E0); optionally record the expected result.
    task automatic do_start1(input bit push);
        if (push) q1.push_back(model(stuck));
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    task automatic sb_compare1(input string tag);
        exp_t e;
        if (q1.size() == 0) begin
            n_vec++;
            n_miss++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            e = q1.pop_front();
            check({tag, "_table"}, tbl1, e.tbl);
            check({tag, "_ones"},  ones1, e.ones);
            check({tag, "_match"}, match1, e.m);
            check({tag, "_busy"},  busy1, 0);
        end
    endtask

    task automatic wait_done1(input string tag, input int budget, input int exp_edges);
        int n = 0;
        while (!done1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_edges);
        sb_compare1(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start1 = 0; abort1 = 0; start3 = 0; abort3 = 0; stuck = 0;
        tick(); tick();
        check("rst_vec",   vec1, 0);
        check("rst_busy",  busy1, 0);
        check("rst_done",  done1, 0);
        check("rst_table", tbl1, 0);
        check("rst_ones",  ones1, 0);
        check("rst_match", match1, 0);
        check("rst3_vec",  vec3, 0);
        rst = 1'b0;
        tick();

        // 1: default sweep, one vector per clock
        do_start1(1);
        for (int k = 0; k < 8; k++) begin
            check("s1_vec",  vec1, k);
            check("s1_busy", busy1, 1);
            check("s1_done", done1, 0);
            tick();
        end
        check("s1_done_final", done1, 1);
        check("s1_vec_last",   vec1, 7);
        sb_compare1("s1");
        tick(); tick();
        check("s1_done_sticky",  done1, 1);
        check("s1_table_stable", tbl1, 8'b1001_0000);

        // 2: stuck-at-0 DUT, then rerun with the correct one
        stuck = 1'b1;
        do_start1(1);
        wait_done1("s2a", 20, 8);
        check("s2a_done", done1, 1);
        stuck = 1'b0;
        do_start1(1);
        check("s2b_done_clr", done1, 0);
        check("s2b_busy",     busy1, 1);
        wait_done1("s2b", 20, 8);

        // 4: start while busy is ignored
        do_start1(1);
        tick(); tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s4_vec", vec1, 3);
        wait_done1("s4", 20, 5);

        // 5: abort mid-sweep, abort alone in IDLE, then start+abort together in IDLE
        do_start1(0);
        tick(); tick(); tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("s5_busy",  busy1, 0);
        check("s5_done",  done1, 0);
        check("s5_match", match1, 0);
        check("s5_vec",   vec1, 0);
        check("s5_table", tbl1, 0);
        check("s5_ones",  ones1, 0);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("s5_idle_abort_busy", busy1, 0);
        q1.push_back(model(stuck));
        start1 = 1'b1; abort1 = 1'b1;
        tick();
        start1 = 1'b0; abort1 = 1'b0;
        check("s5_both_busy", busy1, 1);
        check("s5_both_vec",  vec1, 0);
        wait_done1("s5", 20, 8);

        // 6: reset mid-sweep
        do_start1(0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_vec",   vec1, 0);
        check("s6_busy",  busy1, 0);
        check("s6_done",  done1, 0);
        check("s6_table", tbl1, 0);
        check("s6_ones",  ones1, 0);
        check("s6_match", match1, 0);
        tick();
        check("s6_idle", busy1, 0);
        do_start1(1);
        wait_done1("s6", 20, 8);

        // 3: STEP_CYCLES=3 instance
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check("s3_vec",  vec3, k / 3);
            check("s3_done", done3, 0);
            tick();
        end
        check("s3_done_final", done3, 1);
        check("s3_busy",  busy3, 0);
        check("s3_table", tbl3, 8'b1001_0000);
        check("s3_ones",  ones3, 2);
        check("s3_match", match3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
